window_buffer_ctrl: RTL

WINDOW_BUFFER_CTRL -- requirements
Module: window_buffer_ctrl

---
 rtl/window_buffer_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/window_buffer_ctrl.sv
// Sequences row reads into a 4x16 byte row buffer and sweeps 4x4 windows over it, one read outstanding.
// A window is offered one cycle after its column is set; win_ready low freezes the sweep and all buffer writes/shifts.
module window_buffer_ctrl #(
  parameter int IMG_H  = 16,
  parameter int STRIDE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  output logic [15:0] buf_en,
  output logic        buf_shift,
  output logic [3:0]  buf_adr,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [7:0]  win_row,
  output logic [3:0]  win_col,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_SWEEP  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);
  localparam logic [4:0] STEP     = 5'(STRIDE);
  localparam logic [4:0] MAX_COL  = 5'd12;

  logic [2:0]  state;
  logic [7:0]  row_cnt;
  logic [1:0]  word_cnt;
  logic [15:0] base_q;
  logic [4:0]  next_adr;
  logic        beat;

  // One extra bit so a stride past column 12 is visible instead of wrapping.
  assign next_adr = {1'b0, buf_adr} + STEP;
  assign beat     = (state == S_WAIT) && mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= 8'd0;
      word_cnt  <= 2'd0;
      base_q    <= 16'd0;
      buf_adr   <= 4'd0;
      win_valid <= 1'b0;
      win_row   <= 8'd0;
      win_col   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            row_cnt  <= 8'd0;
            word_cnt <= 2'd0;
            base_q   <= base_addr;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
            if (word_cnt != 2'd3) begin
              word_cnt <= word_cnt + 2'd1;
              state    <= S_FETCH;
            end else if (row_cnt < 8'd3) begin
              state <= S_SHIFT;
            end else begin
              state   <= S_SWEEP;
              buf_adr <= 4'd0;
            end
          end
        end
        S_SHIFT: begin
          row_cnt  <= row_cnt + 8'd1;
          word_cnt <= 2'd0;
          state    <= S_FETCH;
        end
        S_SWEEP: begin
          if (!win_valid) begin
            // buf_adr has been stable for a cycle, so the buffer output is settled.
            win_valid <= 1'b1;
            win_col   <= buf_adr;
            win_row   <= row_cnt - 8'd3;
          end else if (win_ready) begin
            win_valid <= 1'b0;
            if (next_adr <= MAX_COL) begin
              buf_adr <= next_adr[3:0];
            end else if (row_cnt == LAST_ROW) begin
              state <= S_FINISH;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd    = (state == S_FETCH);
  assign mem_addr  = base_q + {6'd0, row_cnt, 2'b00} + {14'd0, word_cnt};
  assign buf_en    = beat ? (16'h8000 >> {word_cnt, 2'b00}) : 16'h0000;
  assign buf_shift = (state == S_SHIFT);
  assign busy      = (state != S_IDLE) && (state != S_FINISH);
  assign done      = (state == S_FINISH);

endmodule
